// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential PC generation against a 1-cycle
// synchronous ROM, a small {pc, instr} buffer, and redirect/flush handling.
module instr_fetch_unit #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned RESET_PC      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    input  logic                     out_ready
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } fetch_entry_t;

    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic                     req_q;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_nxt;
    logic                     issue;
    logic                     push;
    logic                     pop;
    fetch_entry_t             buf_mem [FIFO_DEPTH];

    assign rom_addr  = pc;
    assign out_instr = buf_mem[rd_ptr].instr;
    assign out_pc    = buf_mem[rd_ptr].pc;

    // Credit-based issue, return push, head pop and the resulting occupancy.
    // A same-cycle pop does not return credit, so a push never meets a full buffer.
    always_comb begin
        issue     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        count_nxt = count;
        issue = !redirect_valid &&
                ((SUM_W'(count) + SUM_W'(req_q)) < SUM_W'(FIFO_DEPTH));
        push  = req_q && !redirect_valid;
        pop   = out_valid && out_ready && !redirect_valid;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Fetch control state: PC, in-flight read tracking, buffer pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= ADDRESS_WIDTH'(RESET_PC);
            pc_q      <= '0;
            req_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc        <= redirect_pc;
            req_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            req_q <= issue;
            if (issue) begin
                pc_q <= pc;
                pc   <= pc + ADDRESS_WIDTH'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
        end
    end

    // Buffer storage; contents are don't-care while not covered by count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_mem[wr_ptr] <= '{pc: pc_q, instr: rom_data};
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, all
// checked against a stream-level model (expected next PC, flush timing).
module tb_instr_fetch_unit;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          out_ready;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .FIFO_DEPTH   (DEPTH),
        .RESET_PC     (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready)
    );

    // Synchronous ROM: data appears the cycle after its address.
    logic [DW-1:0] rom [1 << AW];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int            tests     = 0;
    int            fails     = 0;
    int            delivered = 0;
    int            since     = 1000;
    logic [AW-1:0] exp_pc    = '0;
    logic [AW-1:0] flush_pc  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: evaluate the model mid-cycle with current inputs,
    // then advance past the next rising edge.
    task automatic step();
        @(negedge clk);
        if (reset) begin
            exp_pc   = '0;
            flush_pc = '0;
            since    = 0;
        end else begin
            if (since == 1) chk("flush_rom_addr", 64'(rom_addr), 64'(flush_pc));
            if (since == 1 || since == 2) chk("flush_gap", 64'(out_valid), 64'd0);
            if (since == 3) begin
                chk("refill_valid", 64'(out_valid), 64'd1);
                chk("refill_pc", 64'(out_pc), 64'(exp_pc));
            end
            if (out_valid === 1'b1 && out_ready && !redirect_valid) begin
                chk("order_pc", 64'(out_pc), 64'(exp_pc));
                chk("order_instr", 64'(out_instr), 64'(rom[exp_pc]));
                exp_pc = exp_pc + AW'(1);
                delivered++;
            end
            if (redirect_valid) begin
                exp_pc   = redirect_pc;
                flush_pc = redirect_pc;
                since    = 0;
            end
        end
        if (since < 1000) since++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            rom[i] = (i < 'h100) ? DW'(i + 'h100) : $urandom;
        end
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        step();
        step();

        // Scenario 1: first valid two cycles after release, then 1 per cycle.
        reset = 1'b0;
        step();
        step();
        chk("s1_first_valid", 64'(out_valid), 64'd1);
        chk("s1_first_pc", 64'(out_pc), 64'd0);
        chk("s1_first_instr", 64'(out_instr), 64'h100);
        for (int i = 0; i < 8; i++) begin
            chk("s1_stream_valid", 64'(out_valid), 64'd1);
            step();
        end
        chk("s1_stream_pc", 64'(out_pc), 64'd8);

        // Scenario 2: stall saturates the buffer, release streams with no gap.
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        chk("s2_rom_addr_stop", 64'(rom_addr), 64'(DEPTH));
        chk("s2_full_valid", 64'(out_valid), 64'd1);
        chk("s2_head_pc", 64'(out_pc), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("s2_stream_valid", 64'(out_valid), 64'd1);
            step();
        end

        // Scenario 3: redirect with 3 buffered entries and a read in flight.
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = AW'('h200);
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Scenario 4: redirect in the same cycle as a handshake.
        chk("s4_pre_valid", 64'(out_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = AW'('h345);
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Scenario 5: address wrap-around.
        redirect_valid = 1'b1;
        redirect_pc    = AW'('hFFE);
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk("s5_pc_ffe", 64'(out_pc), 64'hFFE);
        step();
        chk("s5_pc_fff", 64'(out_pc), 64'hFFF);
        step();
        chk("s5_pc_000", 64'(out_pc), 64'h000);
        step();
        chk("s5_pc_001", 64'(out_pc), 64'h001);

        // Scenario 6: reset while full with out_ready toggling.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        for (int i = 0; i < 4; i++) begin
            out_ready = ~out_ready;
            step();
        end
        out_ready = 1'b1;
        do_reset();
        chk("s6_valid_low", 64'(out_valid), 64'd0);
        step();
        step();
        chk("s6_restart_pc", 64'(out_pc), 64'd0);
        step();

        // Random traffic: backpressure, redirects (some near wrap), rare resets.
        for (int i = 0; i < 4000; i++) begin
            out_ready      = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(24) == 0);
            redirect_pc    = ($urandom_range(1) == 0) ? AW'($urandom)
                                                      : AW'(12'hFFC + AW'($urandom_range(3)));
            reset          = ($urandom_range(299) == 0);
            step();
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("progress", 64'(delivered > 1000), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
